// File: rtl/dnoc_pkg.sv
// Shared dnoc definitions: head-flit layout, decoded head descriptor, channel FSM states.
package dnoc_pkg;

   localparam int unsigned FLIT_W = 256;
   localparam int unsigned LEN_W  = 13;
   localparam int unsigned ADDR_W = 25;
   localparam int unsigned ID_W   = 4;
   localparam int unsigned LOOP_N = 4;

   // Head-flit bit positions
   localparam int unsigned HD_TGT_LSB      = 0;
   localparam int unsigned HD_RD_RET_BIT   = 12;
   localparam int unsigned HD_RD_DMA_BIT   = 13;
   localparam int unsigned HD_SRC_LSB      = 14;
   localparam int unsigned HD_ADDR_LSB     = 18;
   localparam int unsigned HD_LEN_LSB      = 43;
   localparam int unsigned HD_GAP_LSB      = 56;
   localparam int unsigned HD_LOOP_LEN_LSB = 108;
   localparam int unsigned HD_MC_BIT       = 255;

   // Node-local id reserved for the DMA engine
   localparam logic [ID_W-1:0] DMA_ID = 4'hF;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StHdr  = 2'd1,
      StData = 2'd2
   } dnoc_state_e;

   typedef enum logic {
      DestCore = 1'b0,
      DestDma  = 1'b1
   } dnoc_dest_e;

   typedef struct packed {
      logic                         mc;
      logic [LOOP_N-1:0][LEN_W-1:0] loop_lenth;
      logic [LOOP_N-1:0][LEN_W-1:0] loop_gap;
      logic [LEN_W-1:0]             lenth;
      logic [ADDR_W-1:0]            base_addr;
      logic [ID_W-1:0]              src_id;
      logic                         rd_ret;
      logic [ID_W-1:0]              tgt;
   } dnoc_head_t;

   // Read returns may be steered to the DMA; writes always land in the DMA
   function automatic dnoc_dest_e dnoc_dest_sel(input logic rd_ret, input logic rd_dma);
      if (rd_ret && !rd_dma) begin
         return DestCore;
      end
      return DestDma;
   endfunction

endpackage

// File: rtl/dnoc_head_dec.sv
// Combinational head-flit decoder: raw flit to descriptor plus destination select.
module dnoc_head_dec
   import dnoc_pkg::*;
(
   input  logic [FLIT_W-1:0] flit,
   output dnoc_head_t        head,
   output dnoc_dest_e        dest
);

   // Reserved head bits are ignored
   logic unused_flit;
   assign unused_flit = ^{flit[254:HD_LOOP_LEN_LSB+LOOP_N*LEN_W], flit[11:ID_W]};

   // Slice fields out of the head flit
   always_comb begin
      head            = '0;
      head.mc         = flit[HD_MC_BIT];
      head.loop_lenth = flit[HD_LOOP_LEN_LSB +: LOOP_N*LEN_W];
      head.loop_gap   = flit[HD_GAP_LSB +: LOOP_N*LEN_W];
      head.lenth      = flit[HD_LEN_LSB +: LEN_W];
      head.base_addr  = flit[HD_ADDR_LSB +: ADDR_W];
      head.src_id     = flit[HD_SRC_LSB +: ID_W];
      head.rd_ret     = flit[HD_RD_RET_BIT];
      head.tgt        = flit[HD_TGT_LSB +: ID_W];
      dest            = dnoc_dest_sel(flit[HD_RD_RET_BIT], flit[HD_RD_DMA_BIT]);
   end

endmodule

// File: rtl/dnoc_itf_in_d_channel.sv
// Ingress d-channel: registers the head descriptor, then steers payload to core or DMA sink.
module dnoc_itf_in_d_channel
   import dnoc_pkg::*;
#(
   parameter logic [ID_W-1:0] NODE_ID = 4'd0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [FLIT_W-1:0]            out_flit,
   input  logic                         out_last,
   input  logic                         out_valid,
   output logic                         out_ready,
   output logic [ADDR_W-1:0]            hd_base_addr,
   output logic [LEN_W-1:0]             hd_lenth,
   output logic [LOOP_N-1:0][LEN_W-1:0] hd_loop_lenth,
   output logic [LOOP_N-1:0][LEN_W-1:0] hd_loop_gap,
   output logic [ID_W-1:0]              hd_src_id,
   output logic                         hd_mc,
   output logic                         hd_rd_ret,
   output logic                         hd_core_valid,
   output logic                         hd_dma_valid,
   input  logic                         hd_core_ack,
   input  logic                         hd_dma_ack,
   output logic [FLIT_W-1:0]            core_rd_noc_in_data,
   output logic                         core_rd_noc_in_valid,
   output logic                         core_rd_noc_in_last,
   input  logic                         core_rd_noc_in_ready,
   output logic [FLIT_W-1:0]            dma_wr_noc_in_data,
   output logic                         dma_wr_noc_in_valid,
   output logic                         dma_wr_noc_in_last,
   input  logic                         dma_wr_noc_in_ready,
   output logic                         err_len,
   output logic                         err_id,
   input  logic                         err_clr
);

   dnoc_state_e      state_q, state_d;
   dnoc_head_t       head_q, head_d, dec_head;
   dnoc_dest_e       dest_q, dest_d, dec_dest;
   logic             hlast_q, hlast_d;
   logic             live_q, live_d;
   logic             core_v_q, core_v_d;
   logic             dma_v_q, dma_v_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             err_len_q, err_len_d;
   logic             err_id_q, err_id_d;
   logic             sink_rdy;

   dnoc_head_dec u_head_dec (
      .flit (out_flit),
      .head (dec_head),
      .dest (dec_dest)
   );

   // Next-state, handshake and payload steering
   always_comb begin
      state_d   = state_q;
      head_d    = head_q;
      dest_d    = dest_q;
      hlast_d   = hlast_q;
      live_d    = 1'b1;
      core_v_d  = core_v_q;
      dma_v_d   = dma_v_q;
      cnt_d     = cnt_q;
      err_len_d = err_clr ? 1'b0 : err_len_q;
      err_id_d  = err_clr ? 1'b0 : err_id_q;
      out_ready = 1'b0;
      sink_rdy  = (dest_q == DestDma) ? dma_wr_noc_in_ready : core_rd_noc_in_ready;

      core_rd_noc_in_data  = out_flit;
      core_rd_noc_in_last  = out_last;
      core_rd_noc_in_valid = 1'b0;
      dma_wr_noc_in_data   = out_flit;
      dma_wr_noc_in_last   = out_last;
      dma_wr_noc_in_valid  = 1'b0;

      unique case (state_q)
         StIdle: begin
            // live_q holds ready low through the first cycle out of reset
            out_ready = live_q;
            if (out_valid && live_q) begin
               head_d   = dec_head;
               dest_d   = dec_dest;
               hlast_d  = out_last;
               core_v_d = (dec_dest == DestCore);
               dma_v_d  = (dec_dest == DestDma);
               state_d  = StHdr;
               if (!dec_head.mc && (dec_head.tgt != NODE_ID)) begin
                  err_id_d = 1'b1;
               end
            end
         end
         StHdr: begin
            if ((core_v_q && hd_core_ack) || (dma_v_q && hd_dma_ack)) begin
               core_v_d = 1'b0;
               dma_v_d  = 1'b0;
               cnt_d    = '0;
               state_d  = hlast_q ? StIdle : StData;
            end
         end
         StData: begin
            out_ready            = sink_rdy;
            core_rd_noc_in_valid = out_valid && (dest_q == DestCore);
            dma_wr_noc_in_valid  = out_valid && (dest_q == DestDma);
            if (out_valid && sink_rdy) begin
               if (cnt_q != '1) begin
                  cnt_d = cnt_q + 13'd1;
               end
               if (out_last) begin
                  state_d = StIdle;
                  // Widened compare so a saturated count still mismatches
                  if (!head_q.rd_ret &&
                      (({1'b0, cnt_q} + 14'd1) != {1'b0, head_q.lenth})) begin
                     err_len_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and registered descriptor
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         head_q    <= '0;
         dest_q    <= DestCore;
         hlast_q   <= 1'b0;
         live_q    <= 1'b0;
         core_v_q  <= 1'b0;
         dma_v_q   <= 1'b0;
         cnt_q     <= '0;
         err_len_q <= 1'b0;
         err_id_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         head_q    <= head_d;
         dest_q    <= dest_d;
         hlast_q   <= hlast_d;
         live_q    <= live_d;
         core_v_q  <= core_v_d;
         dma_v_q   <= dma_v_d;
         cnt_q     <= cnt_d;
         err_len_q <= err_len_d;
         err_id_q  <= err_id_d;
      end
   end

   // Target is only checked at capture time
   logic [ID_W-1:0] unused_tgt;
   assign unused_tgt = head_q.tgt;

   assign hd_base_addr  = head_q.base_addr;
   assign hd_lenth      = head_q.lenth;
   assign hd_loop_lenth = head_q.loop_lenth;
   assign hd_loop_gap   = head_q.loop_gap;
   assign hd_src_id     = head_q.src_id;
   assign hd_mc         = head_q.mc;
   assign hd_rd_ret     = head_q.rd_ret;
   assign hd_core_valid = core_v_q;
   assign hd_dma_valid  = dma_v_q;
   assign err_len       = err_len_q;
   assign err_id        = err_id_q;

endmodule
